// File: rtl/video_test_pattern_pkg.sv
// Shared types and colour helpers for the video test-pattern generator.
package video_test_pkg;

  typedef enum logic [1:0] {
    CHECKER  = 2'd0,
    BARS     = 2'd1,
    GRADIENT = 2'd2,
    BOUNCE   = 2'd3
  } mode_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t COLOR_WHITE = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
  localparam rgb_t COLOR_BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};

  // Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic rgb_t bar_color(input logic [2:0] idx);
    rgb_t c;
    c.r = {8{~idx[1]}};
    c.g = {8{~idx[2]}};
    c.b = {8{~idx[0]}};
    return c;
  endfunction

endpackage

// File: rtl/video_test_pattern_if.sv
// Raster-in / pixel-out bundle between the timing generator and the pattern generator.
// No backpressure: de qualifies x/y every cycle, frame_start is a single-cycle pulse in blanking.
interface video_test_pattern_if #(
  parameter int X_WIDTH = 10,
  parameter int Y_WIDTH = 10
);
  logic [X_WIDTH-1:0] x;
  logic [Y_WIDTH-1:0] y;
  logic               de;
  logic               frame_start;
  logic [7:0]         r;
  logic [7:0]         g;
  logic [7:0]         b;
  logic [1:0]         mode;

  modport master (output x, y, de, frame_start, input r, g, b, mode);
  modport slave  (input x, y, de, frame_start, output r, g, b, mode);
endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus counter debouncer; rise pulses one cycle when the stable level goes high.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic rise
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             rise_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= sync2_q;
        rise_q   <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level = stable_q;
  assign rise  = rise_q;

endmodule

// File: rtl/video_test_pattern.sv
// Four-mode test-pattern generator: checker, colour bars, gradient, bouncing square.
// Mode changes only on frame_start; pixel output is registered one cycle behind x/y/de.
module video_test_pattern
  import video_test_pkg::*;
#(
  parameter int HOR_ACTIVE_PIXELS = 800,
  parameter int VER_ACTIVE_PIXELS = 600,
  parameter int CHECKER_LOG2      = 3,
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int SQUARE_SIZE       = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic                 btn,
  video_test_pattern_if.slave vid
);
  localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS);
  localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS);
  localparam int BAR_W   = HOR_ACTIVE_PIXELS / 8;
  localparam logic [X_WIDTH-1:0] SQ_X_MAX = X_WIDTH'(HOR_ACTIVE_PIXELS - SQUARE_SIZE);
  localparam logic [Y_WIDTH-1:0] SQ_Y_MAX = Y_WIDTH'(VER_ACTIVE_PIXELS - SQUARE_SIZE);

  logic               btn_level;
  logic               btn_rise;
  mode_t              mode_q;
  mode_t              pending_q;
  logic [7:0]         frame_cnt_q;
  logic [X_WIDTH-1:0] sq_x_q;
  logic [Y_WIDTH-1:0] sq_y_q;
  logic               dir_x_q;
  logic               dir_y_q;
  rgb_t               pix_d;
  rgb_t               pix_q;
  logic [2:0]         bar_idx;
  logic [7:0]         grad_r;
  logic [7:0]         grad_g;
  logic               in_square;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn),
    .level   (btn_level),
    .rise    (btn_rise)
  );

  // pending_q collects presses; mode_q samples its pre-edge value at frame_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= CHECKER;
      pending_q   <= CHECKER;
      frame_cnt_q <= 8'd0;
      sq_x_q      <= '0;
      sq_y_q      <= '0;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
    end else begin
      if (btn_rise && btn_level) begin
        pending_q <= mode_t'(pending_q + 2'd1);
      end
      if (vid.frame_start) begin
        mode_q      <= pending_q;
        frame_cnt_q <= frame_cnt_q + 8'd1;
        if (dir_x_q) begin
          if (sq_x_q == SQ_X_MAX) begin
            dir_x_q <= 1'b0;
            sq_x_q  <= sq_x_q - 1'b1;
          end else begin
            sq_x_q <= sq_x_q + 1'b1;
          end
        end else begin
          if (sq_x_q == '0) begin
            dir_x_q <= 1'b1;
            sq_x_q  <= sq_x_q + 1'b1;
          end else begin
            sq_x_q <= sq_x_q - 1'b1;
          end
        end
        if (dir_y_q) begin
          if (sq_y_q == SQ_Y_MAX) begin
            dir_y_q <= 1'b0;
            sq_y_q  <= sq_y_q - 1'b1;
          end else begin
            sq_y_q <= sq_y_q + 1'b1;
          end
        end else begin
          if (sq_y_q == '0) begin
            dir_y_q <= 1'b1;
            sq_y_q  <= sq_y_q + 1'b1;
          end else begin
            sq_y_q <= sq_y_q - 1'b1;
          end
        end
      end
    end
  end

  // Bar index by comparator chain rather than a divide.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (32'(vid.x) >= 32'(k * BAR_W)) begin
        bar_idx = bar_idx + 3'd1;
      end
    end
  end

  generate
    if (X_WIDTH >= 8) begin : g_grad_x_top
      assign grad_r = vid.x[X_WIDTH-1 -: 8];
    end else begin : g_grad_x_pad
      assign grad_r = {vid.x, {(8 - X_WIDTH){1'b0}}};
    end
    if (Y_WIDTH >= 8) begin : g_grad_y_top
      assign grad_g = vid.y[Y_WIDTH-1 -: 8];
    end else begin : g_grad_y_pad
      assign grad_g = {vid.y, {(8 - Y_WIDTH){1'b0}}};
    end
  endgenerate

  assign in_square = (32'(vid.x) >= 32'(sq_x_q)) &&
                     (32'(vid.x) <  32'(sq_x_q) + 32'(SQUARE_SIZE)) &&
                     (32'(vid.y) >= 32'(sq_y_q)) &&
                     (32'(vid.y) <  32'(sq_y_q) + 32'(SQUARE_SIZE));

  always_comb begin
    pix_d = COLOR_BLACK;
    if (vid.de) begin
      case (mode_q)
        CHECKER:  pix_d = (vid.x[CHECKER_LOG2] ^ vid.y[CHECKER_LOG2]) ? COLOR_WHITE : COLOR_BLACK;
        BARS:     pix_d = bar_color(bar_idx);
        GRADIENT: pix_d = '{r: grad_r, g: grad_g, b: frame_cnt_q};
        BOUNCE:   pix_d = in_square ? COLOR_WHITE : COLOR_BLACK;
        default:  pix_d = COLOR_BLACK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q <= COLOR_BLACK;
    end else begin
      pix_q <= pix_d;
    end
  end

  assign vid.r    = pix_q.r;
  assign vid.g    = pix_q.g;
  assign vid.b    = pix_q.b;
  assign vid.mode = mode_q;

endmodule

// File: doc/video_test_pattern.md
Name: video_test_pattern

Overview:
Parametrised, multi-mode test-pattern generator for the video pipeline. It takes the raster position from the timing generator and drives 8-bit RGB.
- Four selectable patterns: checkerboard, colour bars, gradient, bouncing square.
- A debounced push-button cycles the mode.
- Mode changes are frame-synchronous, so the display never tears.
- Output is registered, one cycle behind the raster position.

Parameters:
HOR_ACTIVE_PIXELS, 800, active pixels per line
VER_ACTIVE_PIXELS, 600, active lines per frame
CHECKER_LOG2, 3, checker cell edge = 2**CHECKER_LOG2 pixels
DEBOUNCE_CYCLES, 250000, consecutive stable clk cycles needed to accept a button level
SQUARE_SIZE, 32, bouncing-square edge in pixels (< both active dimensions)

Ports:
clk  input  1  pixel clock
rst_n  input  1  reset, asynchronous, active-low
x  input  X_WIDTH=$clog2(HOR_ACTIVE_PIXELS)  current pixel column
y  input  Y_WIDTH=$clog2(VER_ACTIVE_PIXELS)  current pixel row
de  input  1  data enable, high in active region
frame_start  input  1  one-cycle pulse per frame, always during blanking (de=0)
btn  input  1  raw asynchronous push-button, active-high
r, g, b  output  8 each  registered pixel colour
mode  output  2  currently active pattern (debug/LED)

Behaviour:
- Reset (async, rst_n=0):
  - r, g, b = 0; mode = 0; pending mode = 0.
  - frame counter = 0; square at (0,0), direction +x, +y.
  - Debouncer state = 0; synchroniser flops = 0.
- Button path:
  - 2-flop synchroniser, then debouncer.
  - Counter clears whenever the synced level equals the stable level.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the levels still differing, the stable level takes the synced level.
  - Each stable 0->1 edge increments pending_mode (2-bit, 3->0 wrap).
  - Several presses in one frame accumulate.
- Frame update, on the frame_start cycle:
  - mode <= pending_mode, using the value held before any edge in that same cycle; a press coinciding with frame_start takes effect the following frame.
  - 8-bit frame counter increments, wrapping 255->0.
  - Square position steps, independently per axis, in the square's current x/y direction.
  - If the square already sits at the limit (0 or ACTIVE-SQUARE_SIZE) in its direction of travel, the direction flips and it steps one pixel the new way. It never exceeds the limits.
- Pixel output:
  - Registered, latency 1: r/g/b at cycle n+1 reflect x, y, de, mode at cycle n.
  - de=0 gives 0,0,0 regardless of mode.
- Mode 0, CHECKER: white (255 all channels) if x[CHECKER_LOG2] ^ y[CHECKER_LOG2], else black.
- Mode 1, BARS: 8 bars, BAR_W = HOR_ACTIVE_PIXELS/8.
  - Bar index i = count of k in 1..7 with x >= k*BAR_W, done with a comparator chain, no divider.
  - Colour: r = ~i[1], g = ~i[2], b = ~i[0], each bit expanded to 0/255.
  - Order: white, yellow, cyan, green, magenta, red, blue, black.
- Mode 2, GRADIENT:
  - r = x left-aligned to 8 bits: top 8 bits if X_WIDTH >= 8, else zero-padded at the LSBs.
  - g = y, treated the same way.
  - b = frame counter.
- Mode 3, BOUNCE: white if sq_x <= x < sq_x+SQUARE_SIZE and sq_y <= y < sq_y+SQUARE_SIZE, else black.
- Reset mid-frame: outputs go to 0 immediately, and the next frame starts in mode 0.

Decomposition:
- Package video_test_pkg:
  - mode_t enum: CHECKER, BARS, GRADIENT, BOUNCE.
  - COLOR_WHITE / COLOR_BLACK constants.
  - Bar-index-to-RGB function.
- Sub-module button_debouncer (params DEBOUNCE_CYCLES; ports clk, rst_n, btn_raw, level, rise). It contains the synchroniser and is reusable for future buttons.
- Pattern logic, square motion and output register stay in video_test_pattern.

Test Plan (params HOR=64, VER=48, CHECKER_LOG2=2, DEBOUNCE_CYCLES=4, SQUARE_SIZE=8):
1. After reset, de=1:
   - x=4, y=0 -> next cycle rgb=(255,255,255).
   - x=4, y=4 -> (0,0,0).
   - x=0, y=0 -> (0,0,0).
2. Press once, then frame_start -> mode=1:
   - x=8 -> (255,255,0).
   - x=63 -> (0,0,0).
   - x=0 -> (255,255,255).
3. Bounce on btn: 1,0,1 on consecutive cycles, then 1 held for 6 cycles:
   - exactly one increment.
   - mode unchanged until the next frame_start, then +1.
   - A press landing in the frame_start cycle appears one frame later.
4. Mode 3 after 56 frame_starts: sq=(56,24).
   - Next frame_start gives sq_x=55 (x direction reversed).
   - Pixel (55,24) white, (54,24) black, (55,32) black.
5. Mode 2 after 5 frames: x=32, y=16 -> (128,64,5); frame counter wraps 255->0 after 256 frames.
6. de=0 in every mode -> (0,0,0). Assert rst_n=0 mid-line in mode 3 -> rgb=0 and mode=0 immediately, without waiting for a clock edge.
